// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the LCD controller command path:
// command codes, host FSM states and frame geometry.
package lcd_ctrl_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE       = 4'h0,
    CMD_SHIFT_UP    = 4'h1,
    CMD_SHIFT_DOWN  = 4'h2,
    CMD_SHIFT_LEFT  = 4'h3,
    CMD_SHIFT_RIGHT = 4'h4,
    CMD_MAX         = 4'h5,
    CMD_MIN         = 4'h6,
    CMD_AVG         = 4'h7,
    CMD_ROT_CCW     = 4'h8,
    CMD_ROT_CW      = 4'h9,
    CMD_MIRROR_X    = 4'hA,
    CMD_MIRROR_Y    = 4'hB
  } lcd_cmd_t;

  localparam logic [3:0] CMD_LAST = 4'(CMD_MIRROR_Y);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_READY,
    ST_ACK,
    ST_RUN
  } host_state_t;

  localparam int IMG_SIDE   = 8;
  localparam int FRAME_SIZE = IMG_SIDE * IMG_SIDE;

  function automatic logic cmd_legal(input logic [3:0] c);
    return c <= CMD_LAST;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO, head word visible on rd_data.
// Pushes while full are dropped even if a pop happens the same cycle.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [3:0] wr_data,
  input  logic       pop,
  output logic [3:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lcd_cmd_host.sv
// Issues buffered commands to LCD_CTRL one at a time, honouring busy,
// and monitors the IRAM write port for frame count, order and checksum.
module lcd_cmd_host
  import lcd_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  in_cmd,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  cmd,
  output logic        cmd_valid,
  input  logic        busy,
  input  logic        done,
  input  logic        IRAM_valid,
  input  logic [5:0]  IRAM_A,
  input  logic [7:0]  IRAM_D,
  output logic        idle,
  output logic        frame_done,
  output logic [6:0]  wr_count,
  output logic [13:0] checksum,
  output logic        err_cmd,
  output logic        err_ack,
  output logic        err_addr
);

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] ACK_LIM = TW'(ACK_TIMEOUT - 1);
  localparam logic [6:0]    WR_MAX  = 7'(FRAME_SIZE);

  host_state_t   state;
  logic [TW-1:0] ack_cnt;
  logic [3:0]    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          issue_wr;
  logic          unused_done;

  // done is a sticky debug flag only; completion comes from busy falling
  assign unused_done = done;

  assign in_ready   = !fifo_full;
  assign idle       = fifo_empty && (state == ST_READY);
  assign pop        = (state == ST_READY) && !fifo_empty && !busy;
  assign issue_wr   = pop && (head == CMD_WRITE);
  assign frame_done = (state == ST_RUN) && !busy && (cmd == CMD_WRITE);

  lcd_cmd_fifo #(
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (in_valid),
    .wr_data (in_cmd),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      cmd       <= 4'h0;
      cmd_valid <= 1'b0;
      ack_cnt   <= '0;
      err_cmd   <= 1'b0;
      err_ack   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      unique case (state)
        ST_INIT: begin
          if (!busy) state <= ST_READY;
        end
        ST_READY: begin
          if (pop) begin
            if (cmd_legal(head)) begin
              cmd       <= head;
              cmd_valid <= 1'b1;
              ack_cnt   <= '0;
              state     <= ST_ACK;
            end else begin
              err_cmd <= 1'b1;
            end
          end
        end
        ST_ACK: begin
          if (busy) begin
            state <= ST_RUN;
          end else if (ack_cnt == ACK_LIM) begin
            err_ack <= 1'b1;
            state   <= ST_READY;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!busy) state <= ST_READY;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // expected IRAM address equals the number of writes seen this frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_count <= 7'd0;
      checksum <= 14'd0;
      err_addr <= 1'b0;
    end else if (issue_wr) begin
      wr_count <= 7'd0;
      checksum <= 14'd0;
    end else if (IRAM_valid) begin
      if ((wr_count == WR_MAX) || (IRAM_A != wr_count[5:0]))
        err_addr <= 1'b1;
      checksum <= checksum + {6'd0, IRAM_D};
      if (wr_count != WR_MAX) wr_count <= wr_count + 7'd1;
    end
  end

endmodule
